// File: rtl/fpu_issue_queue.sv
// fpu_issue_queue
// Operand/command issue queue sitting directly in front of the fpu.
// Accepts {a, b, command, tag} entries over a valid/ready handshake, drops
// illegal commands (raising a sticky error), and presents the oldest entry
// to the fpu's input_rdy/input_ack handshake. The tag of every entry the
// fpu consumes is reported one cycle later so results can be matched up.
module fpu_issue_queue #(
    parameter int bitness   = 32,
    parameter int depth     = 4,
    parameter int tag_width = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [bitness-1:0]     in_a,
    input  logic [bitness-1:0]     in_b,
    input  logic [3:0]             in_command,
    input  logic [tag_width-1:0]   in_tag,
    input  logic                   flush,
    output logic                   fpu_input_rdy,
    input  logic                   fpu_input_ack,
    output logic [bitness-1:0]     fpu_data_a,
    output logic [bitness-1:0]     fpu_data_b,
    output logic [3:0]             fpu_command,
    output logic                   issued_strobe,
    output logic [tag_width-1:0]   issued_tag,
    output logic [$clog2(depth):0] count,
    output logic                   err_illegal
);

    // Index width plus one wrap bit distinguishes full from empty.
    localparam int AW = $clog2(depth);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] PTR_ZERO = {PW{1'b0}};
    localparam logic [PW-1:0] PTR_ONE  = {{(PW-1){1'b0}}, 1'b1};

    // Entry storage: deliberately not reset, validity comes from the pointers.
    logic [bitness-1:0]   r_mem_a   [depth];
    logic [bitness-1:0]   r_mem_b   [depth];
    logic [3:0]           r_mem_cmd [depth];
    logic [tag_width-1:0] r_mem_tag [depth];

    logic [PW-1:0]        r_wr_ptr;
    logic [PW-1:0]        r_rd_ptr;
    logic [PW-1:0]        r_count;
    logic                 r_issued_strobe;
    logic [tag_width-1:0] r_issued_tag;
    logic                 r_err_illegal;

    logic [AW-1:0]        w_wr_idx;
    logic [AW-1:0]        w_rd_idx;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_legal;
    logic                 w_accept;
    logic                 w_push;
    logic                 w_drop;
    logic                 w_pop;
    logic [PW-1:0]        w_wr_next;
    logic [PW-1:0]        w_rd_next;

    assign w_wr_idx = r_wr_ptr[AW-1:0];
    assign w_rd_idx = r_rd_ptr[AW-1:0];

    // Full: same slot, opposite lap. Empty: identical pointers.
    assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (w_wr_idx == w_rd_idx);
    assign w_empty = (r_wr_ptr == r_rd_ptr);

    // Only commands 0..3 (add, sub, mul, div) are legal.
    assign w_legal = (in_command[3:2] == 2'b00);

    // No bypass: a full queue refuses even when the head is leaving this cycle.
    assign in_ready = reset && !w_full;

    // flush swallows both sides of the handshake in the same cycle.
    assign w_accept = in_valid && in_ready && !flush;
    assign w_push   = w_accept && w_legal;
    assign w_drop   = w_accept && !w_legal;
    assign w_pop    = !w_empty && fpu_input_ack && !flush;

    // Next pointer values, shared by the pointer and occupancy registers.
    always_comb begin
        w_wr_next = r_wr_ptr;
        w_rd_next = r_rd_ptr;
        if (flush) begin
            w_wr_next = PTR_ZERO;
            w_rd_next = PTR_ZERO;
        end else begin
            if (w_push) begin
                w_wr_next = r_wr_ptr + PTR_ONE;
            end else begin
                w_wr_next = r_wr_ptr;
            end
            if (w_pop) begin
                w_rd_next = r_rd_ptr + PTR_ONE;
            end else begin
                w_rd_next = r_rd_ptr;
            end
        end
    end

    // Write an accepted legal entry into the slot under the write pointer.
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem_a[w_wr_idx]   <= in_a;
            r_mem_b[w_wr_idx]   <= in_b;
            r_mem_cmd[w_wr_idx] <= in_command;
            r_mem_tag[w_wr_idx] <= in_tag;
        end
    end

    // Pointers and registered occupancy (difference wraps modulo 2*depth).
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= PTR_ZERO;
            r_rd_ptr <= PTR_ZERO;
            r_count  <= PTR_ZERO;
        end else begin
            r_wr_ptr <= w_wr_next;
            r_rd_ptr <= w_rd_next;
            r_count  <= w_wr_next - w_rd_next;
        end
    end

    // One-cycle issue pulse carrying the consumed entry's tag; tag holds after.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_issued_strobe <= 1'b0;
            r_issued_tag    <= {tag_width{1'b0}};
        end else begin
            r_issued_strobe <= w_pop;
            if (w_pop) begin
                r_issued_tag <= r_mem_tag[w_rd_idx];
            end else begin
                r_issued_tag <= r_issued_tag;
            end
        end
    end

    // Sticky illegal-command flag; flush clears it and wins over a new drop.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_err_illegal <= 1'b0;
        end else if (flush) begin
            r_err_illegal <= 1'b0;
        end else if (w_drop) begin
            r_err_illegal <= 1'b1;
        end else begin
            r_err_illegal <= r_err_illegal;
        end
    end

    // Head entry is read straight from storage so the fpu sees it right away.
    assign fpu_input_rdy = !w_empty;
    assign fpu_data_a    = r_mem_a[w_rd_idx];
    assign fpu_data_b    = r_mem_b[w_rd_idx];
    assign fpu_command   = r_mem_cmd[w_rd_idx];

    assign issued_strobe = r_issued_strobe;
    assign issued_tag    = r_issued_tag;
    assign count         = r_count;
    assign err_illegal   = r_err_illegal;

endmodule

// File: tb/tb_fpu_issue_queue.sv
// Self-checking bench for fpu_issue_queue: directed scenarios plus a random
// run, all compared against a queue-based reference model.
module tb_fpu_issue_queue;

    localparam int DEPTH = 4;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  cmd;
        logic [3:0]  tag;
    } ent_t;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [3:0]  in_command;
    logic [3:0]  in_tag;
    logic        flush;
    logic        fpu_input_rdy;
    logic        fpu_input_ack;
    logic [31:0] fpu_data_a;
    logic [31:0] fpu_data_b;
    logic [3:0]  fpu_command;
    logic        issued_strobe;
    logic [3:0]  issued_tag;
    logic [2:0]  count;
    logic        err_illegal;

    int checks = 0;
    int errors = 0;

    // Reference model state
    ent_t     mq[$];
    logic     m_strobe = 1'b0;
    logic [3:0] m_tag  = 4'd0;
    logic     m_err    = 1'b0;

    always #5 clock = ~clock;

    fpu_issue_queue #(.bitness(32), .depth(DEPTH), .tag_width(4)) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_command(in_command), .in_tag(in_tag),
        .flush(flush), .fpu_input_rdy(fpu_input_rdy), .fpu_input_ack(fpu_input_ack),
        .fpu_data_a(fpu_data_a), .fpu_data_b(fpu_data_b), .fpu_command(fpu_command),
        .issued_strobe(issued_strobe), .issued_tag(issued_tag), .count(count),
        .err_illegal(err_illegal)
    );

    // Advance one clock edge and apply the queue rules to the model.
    task automatic tick();
        bit   push_hs;
        bit   pop;
        ent_t e;
        ent_t head;
        push_hs = in_valid && (mq.size() < DEPTH) && !flush;
        pop     = (mq.size() > 0) && fpu_input_ack && !flush;
        e.a = in_a; e.b = in_b; e.cmd = in_command; e.tag = in_tag;
        head = '0;
        if (pop) head = mq[0];
        @(posedge clock);
        if (flush) begin
            mq.delete();
            m_strobe = 1'b0;
            m_err    = 1'b0;
        end else begin
            m_strobe = pop;
            if (pop) begin
                m_tag = head.tag;
                void'(mq.pop_front());
            end
            if (push_hs) begin
                if (e.cmd < 4'd4) mq.push_back(e);
                else m_err = 1'b1;
            end
        end
        #1;
    endtask

    task automatic model_reset();
        mq.delete();
        m_strobe = 1'b0;
        m_tag    = 4'd0;
        m_err    = 1'b0;
    endtask

    task automatic idle_inputs();
        in_valid = 1'b0; in_a = 32'd0; in_b = 32'd0; in_command = 4'd0;
        in_tag = 4'd0; flush = 1'b0; fpu_input_ack = 1'b0;
    endtask

    task automatic push_one(input logic [3:0] cmd, input logic [3:0] tag);
        in_valid = 1'b1; in_a = $urandom; in_b = $urandom;
        in_command = cmd; in_tag = tag;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        idle_inputs();
        model_reset();
        #12;
        checks++;
        if ({in_ready, fpu_input_rdy, count, issued_strobe, issued_tag, err_illegal} !== 10'd0) begin
            errors++;
            $display("FAIL reset_state: got rdy=%b frdy=%b cnt=%0d stb=%b tag=%0d err=%b expected all zero",
                     in_ready, fpu_input_rdy, count, issued_strobe, issued_tag, err_illegal);
        end
        reset = 1'b1;
        tick();
        checks++;
        if (in_ready !== 1'b1 || fpu_input_rdy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: got in_ready=%b fpu_rdy=%b expected 1 0", in_ready, fpu_input_rdy);
        end
    endtask

    task automatic test_single();
        in_valid = 1'b1; in_a = 32'h3F800000; in_b = 32'h40000000;
        in_command = 4'd0; in_tag = 4'd5;
        tick();
        in_valid = 1'b0;
        checks++;
        if (fpu_input_rdy !== 1'b1 || fpu_data_a !== 32'h3F800000 || fpu_data_b !== 32'h40000000
            || fpu_command !== 4'd0 || count !== 3'd1) begin
            errors++;
            $display("FAIL single_push: got rdy=%b a=%h b=%h cmd=%0d cnt=%0d expected 1 3f800000 40000000 0 1",
                     fpu_input_rdy, fpu_data_a, fpu_data_b, fpu_command, count);
        end
        fpu_input_ack = 1'b1;
        tick();
        fpu_input_ack = 1'b0;
        checks++;
        if (issued_strobe !== 1'b1 || issued_tag !== 4'd5 || count !== 3'd0 || fpu_input_rdy !== 1'b0) begin
            errors++;
            $display("FAIL single_pop: got stb=%b tag=%0d cnt=%0d rdy=%b expected 1 5 0 0",
                     issued_strobe, issued_tag, count, fpu_input_rdy);
        end
        tick();
        checks++;
        if (issued_strobe !== 1'b0 || issued_tag !== 4'd5) begin
            errors++;
            $display("FAIL strobe_pulse: got stb=%b tag=%0d expected 0 5", issued_strobe, issued_tag);
        end
    endtask

    task automatic test_full();
        for (int i = 0; i < DEPTH; i++) push_one(i[3:0] & 4'd3, i[3:0]);
        checks++;
        if (count !== 3'd4 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL fill: got cnt=%0d in_ready=%b expected 4 0", count, in_ready);
        end
        push_one(4'd1, 4'd9);
        checks++;
        if (count !== 3'd4 || int'(count) != mq.size()) begin
            errors++;
            $display("FAIL push_when_full: got cnt=%0d expected 4", count);
        end
        fpu_input_ack = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            tick();
            checks++;
            if (issued_strobe !== 1'b1 || issued_tag !== i[3:0] || issued_tag !== m_tag) begin
                errors++;
                $display("FAIL drain_order: got stb=%b tag=%0d expected 1 %0d", issued_strobe, issued_tag, i);
            end
        end
        fpu_input_ack = 1'b0;
        checks++;
        if (count !== 3'd0 || fpu_input_rdy !== 1'b0) begin
            errors++;
            $display("FAIL drained: got cnt=%0d rdy=%b expected 0 0", count, fpu_input_rdy);
        end
    endtask

    task automatic test_back_to_back();
        push_one(4'd2, 4'd10);
        push_one(4'd3, 4'd11);
        for (int k = 0; k < 10; k++) begin
            logic [3:0] exp_tag;
            exp_tag = (k < 2) ? 4'(10 + k) : 4'(k - 2);
            in_valid = 1'b1; in_a = $urandom; in_b = $urandom;
            in_command = 4'(k % 4); in_tag = 4'(k);
            fpu_input_ack = 1'b1;
            tick();
            checks++;
            if (count !== 3'd2 || issued_strobe !== 1'b1 || issued_tag !== exp_tag || issued_tag !== m_tag) begin
                errors++;
                $display("FAIL back_to_back: got cnt=%0d stb=%b tag=%0d expected 2 1 %0d",
                         count, issued_strobe, issued_tag, exp_tag);
            end
        end
        in_valid = 1'b0;
        tick();
        tick();
        fpu_input_ack = 1'b0;
        checks++;
        if (count !== 3'd0 || issued_tag !== 4'd9) begin
            errors++;
            $display("FAIL b2b_drain: got cnt=%0d tag=%0d expected 0 9", count, issued_tag);
        end
    endtask

    task automatic test_illegal();
        in_valid = 1'b1; in_command = 4'h9; in_tag = 4'd7; in_a = $urandom; in_b = $urandom;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL illegal_ready: got %b expected 1", in_ready);
        end
        tick();
        in_valid = 1'b0;
        checks++;
        if (count !== 3'd0 || err_illegal !== 1'b1 || fpu_input_rdy !== 1'b0) begin
            errors++;
            $display("FAIL illegal_drop: got cnt=%0d err=%b rdy=%b expected 0 1 0", count, err_illegal, fpu_input_rdy);
        end
        push_one(4'd2, 4'd3);
        checks++;
        if (count !== 3'd1 || err_illegal !== 1'b1 || fpu_command !== 4'd2) begin
            errors++;
            $display("FAIL legal_after_illegal: got cnt=%0d err=%b cmd=%0d expected 1 1 2", count, err_illegal, fpu_command);
        end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checks++;
        if (err_illegal !== 1'b0 || count !== 3'd0) begin
            errors++;
            $display("FAIL flush_clears_err: got err=%b cnt=%0d expected 0 0", err_illegal, count);
        end
    endtask

    task automatic test_flush();
        push_one(4'd0, 4'd1);
        push_one(4'd1, 4'd2);
        push_one(4'd2, 4'd3);
        flush = 1'b1; in_valid = 1'b1; in_command = 4'd0; in_tag = 4'd4; fpu_input_ack = 1'b1;
        tick();
        idle_inputs();
        checks++;
        if (count !== 3'd0 || fpu_input_rdy !== 1'b0 || issued_strobe !== 1'b0) begin
            errors++;
            $display("FAIL flush: got cnt=%0d rdy=%b stb=%b expected 0 0 0", count, fpu_input_rdy, issued_strobe);
        end
        tick();
        checks++;
        if (count !== 3'd0 || fpu_input_rdy !== 1'b0) begin
            errors++;
            $display("FAIL flush_push_lost: got cnt=%0d rdy=%b expected 0 0", count, fpu_input_rdy);
        end
    endtask

    task automatic test_async_reset();
        push_one(4'd0, 4'd6);
        push_one(4'd3, 4'd8);
        #3;
        reset = 1'b0;
        #1;
        model_reset();
        checks++;
        if (count !== 3'd0 || fpu_input_rdy !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: got cnt=%0d rdy=%b in_ready=%b expected 0 0 0", count, fpu_input_rdy, in_ready);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1 || fpu_input_rdy !== 1'b0 || count !== 3'd0) begin
            errors++;
            $display("FAIL reset_recover: got in_ready=%b rdy=%b cnt=%0d expected 1 0 0", in_ready, fpu_input_rdy, count);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            in_valid      = ($urandom_range(0, 9) < 6);
            in_a          = $urandom;
            in_b          = $urandom;
            in_command    = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(4, 15)) : 4'($urandom_range(0, 3));
            in_tag        = 4'($urandom_range(0, 15));
            fpu_input_ack = ($urandom_range(0, 1) == 1);
            flush         = ($urandom_range(0, 39) == 0);
            tick();
            checks++;
            if (int'(count) != mq.size() || fpu_input_rdy !== (mq.size() != 0)
                || in_ready !== (mq.size() < DEPTH) || issued_strobe !== m_strobe
                || issued_tag !== m_tag || err_illegal !== m_err) begin
                errors++;
                $display("FAIL random_ctl cycle %0d: got cnt=%0d rdy=%b in_rdy=%b stb=%b tag=%0d err=%b expected %0d %b %b %b %0d %b",
                         c, count, fpu_input_rdy, in_ready, issued_strobe, issued_tag, err_illegal,
                         mq.size(), (mq.size() != 0), (mq.size() < DEPTH), m_strobe, m_tag, m_err);
            end
            if (mq.size() > 0) begin
                checks++;
                if (fpu_data_a !== mq[0].a || fpu_data_b !== mq[0].b || fpu_command !== mq[0].cmd) begin
                    errors++;
                    $display("FAIL random_head cycle %0d: got a=%h b=%h cmd=%0d expected %h %h %0d",
                             c, fpu_data_a, fpu_data_b, fpu_command, mq[0].a, mq[0].b, mq[0].cmd);
                end
            end
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_single();
        test_full();
        test_back_to_back();
        test_illegal();
        test_flush();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fpu_issue_queue.md
Name: fpu_issue_queue

Overview:
- Operand/command issue queue placed directly upstream of the fpu.
- Buffers up to depth operand pairs from a requester using a valid/ready handshake. Presents the head entry to the fpu's input_rdy/input_ack handshake.
- Filters illegal commands and reports the tag of each operation handed to the fpu, so downstream logic can match results.

Parameters:
bitness, 32, operand width; must match the fpu bitness.
depth, 4, queue entries; power of two, minimum 2.
tag_width, 4, width of the requester-supplied operation tag.

Ports:
clock  in  1  single clock, rising edge.
reset  in  1  asynchronous, active-low reset.
in_valid  in  1  requester offers an entry.
in_ready  out  1  queue can accept an entry.
in_a  in  bitness  operand A.
in_b  in  bitness  operand B.
in_command  in  4  0=add, 1=sub, 2=mul, 3=div; 4..15 illegal.
in_tag  in  tag_width  requester tag.
flush  in  1  synchronous queue clear.
fpu_input_rdy  out  1  head entry valid; drives fpu input_rdy.
fpu_input_ack  in  1  fpu input_ack.
fpu_data_a  out  bitness  head operand A.
fpu_data_b  out  bitness  head operand B.
fpu_command  out  4  head command.
issued_strobe  out  1  one-cycle pulse: an entry was consumed by the fpu.
issued_tag  out  tag_width  tag of the last consumed entry.
count  out  $clog2(depth)+1  number of occupied entries.
err_illegal  out  1  sticky flag: an illegal command was dropped.

Behaviour:
- Reset (reset=0, asynchronous):
  - Pointers cleared; count=0; issued_strobe=0; issued_tag=0; err_illegal=0; fpu_input_rdy=0.
  - in_ready is forced 0 while reset is low.
  - Entry storage is not reset.
  - Reset asserted mid-operation discards all entries immediately.
- Storage: circular buffer of depth entries {a, b, command, tag}. Read pointer and write pointer each have one extra wrap bit.
  - full = pointers equal except the wrap bit.
  - empty = pointers fully equal.
  - Pointers wrap naturally from depth-1 to 0.
- in_ready = !full (and reset high). There is no bypass: a full queue does not accept an entry even when a pop occurs in the same cycle.
- Push occurs when in_valid && in_ready && !flush.
  - Legal command: the entry is written at the write pointer, which then increments.
  - Illegal command (>3): the handshake still completes, nothing is written, err_illegal <= 1.
- fpu_input_rdy = !empty. fpu_data_a, fpu_data_b and fpu_command reflect the head entry combinationally from storage, and are stable while fpu_input_rdy=1 and no pop has occurred.
- Pop occurs when fpu_input_rdy && fpu_input_ack && !flush. The read pointer increments.
  - Next cycle: issued_strobe=1 and issued_tag = the popped entry's tag.
  - Otherwise issued_strobe=0. issued_tag holds its last value.
- Simultaneous push and pop (not full, not empty): both happen and count is unchanged.
- Latency: an entry pushed into an empty queue at edge N is visible on fpu_input_rdy after edge N; the earliest pop is at edge N+1. Ordering is strictly FIFO.
- fpu_input_ack high while empty is ignored.
- flush=1 at a rising edge:
  - Both pointers are cleared and count=0.
  - Any push or pop in the same cycle is discarded: no issued_strobe, no err_illegal update.
  - err_illegal is cleared.
  - flush has priority over every other event.
- count = write pointer - read pointer, modulo 2*depth, registered; range 0..depth.

Test Plan:
- Reset, then push {a=32'h3F800000, b=32'h40000000, cmd=0, tag=5} with fpu_input_ack=0 -> fpu_input_rdy=1 one cycle later, fpu_data_a=32'h3F800000, count=1. Then ack=1 for one cycle -> issued_strobe pulse, issued_tag=5, count=0, fpu_input_rdy=0.
- Push tags 0..3 (depth=4) with no ack -> count=4, in_ready=0. A 5th push with in_valid=1 is not accepted. Pop four entries -> tags issued in order 0,1,2,3.
- Push and pop in the same cycle at count=2, then repeat across 10 entries -> count stays 2 after the initial fill, pointers wrap, tag order preserved.
- Push cmd=4'h9, tag=7 -> in_ready=1 handshake completes, count unchanged, err_illegal=1. Next legal push proceeds normally. Flush -> err_illegal=0.
- Fill 3 entries, assert flush together with in_valid=1 and fpu_input_ack=1 -> count=0, fpu_input_rdy=0, no issued_strobe, pushed entry lost.
- With 2 entries queued, pull reset low between clock edges -> count=0, fpu_input_rdy=0 and in_ready=0 immediately. After release: in_ready=1, queue empty.
